rom_select_ctrl: RTL

//  Turns the raw front-panel select button into the ROM-reload request and ROM

---
 rtl/rom_select_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rom_select_ctrl.sv
// Front-panel select button handling: synchronise and debounce the pad, classify
// short/long presses, and hand the ROM loader a reload pulse plus ROM index.
module rom_select_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 65536,
    parameter int LONG_PRESS_CYCLES = 16777216,
    parameter int NUM_ROMS          = 8,
    parameter int INDEX_W           = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_n,
    input  logic               load_done,
    output logic               reload,
    output logic [INDEX_W-1:0] index,
    output logic               pending,
    output logic               long_held,
    output logic [1:0]         fsm_state
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LP_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;

    localparam logic [DB_W-1:0]    DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0]    LP_LAST  = LP_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [INDEX_W-1:0] IDX_LAST = INDEX_W'(NUM_ROMS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;
    localparam logic [1:0] ST_PENDING = 2'd3;

    logic            sync1;
    logic            sync2;
    logic            db_level;
    logic            db_prev;
    logic [DB_W-1:0] db_cnt;
    logic [LP_W-1:0] hold_cnt;
    logic [1:0]      state;
    logic            press_edge;
    logic            rel_edge;

    // Pad is asynchronous; released (high) is the safe reset value.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            db_level <= 1'b1;
            db_prev  <= 1'b1;
            db_cnt   <= '0;
        end else begin
            db_prev <= db_level;
            if (sync2 == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Active-low button: press is the debounced falling edge.
    assign press_edge = db_prev & ~db_level;
    assign rel_edge   = ~db_prev & db_level;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            index     <= '0;
            long_held <= 1'b0;
            reload    <= 1'b0;
        end else begin
            reload <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (press_edge) begin
                        state    <= ST_PRESSED;
                        hold_cnt <= '0;
                    end
                end
                ST_PRESSED: begin
                    if (hold_cnt != LP_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    // Release is checked first so a coincident threshold still counts as short.
                    if (rel_edge) begin
                        state <= ST_PENDING;
                        index <= (index == IDX_LAST) ? '0 : index + 1'b1;
                    end else if (hold_cnt == LP_LAST) begin
                        state     <= ST_LONG;
                        long_held <= 1'b1;
                    end
                end
                ST_LONG: begin
                    if (rel_edge) begin
                        state     <= ST_PENDING;
                        long_held <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    // Press edges arriving here are dropped on purpose.
                    if (load_done) begin
                        reload <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign pending   = (state == ST_PENDING);
    assign fsm_state = state;

endmodule
